// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback
// and counts retired instructions. Optional illegal-opcode trap under ILLEGAL_INSN_TRAP_EN.
module multicycle_ctrl #(
   parameter int INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [6:0]           opcode,
   input  logic [2:0]           funct3,
   input  logic                 alu_zero,
   input  logic                 alu_lsb,
   input  logic                 mem_ready,
   output logic                 mem_re,
   output logic                 mem_we,
   output logic                 adr_src,
   output logic                 ir_we,
   output logic                 pc_we,
   output logic                 rf_we,
   output logic                 alu_ctrl,
   output logic [1:0]           alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           result_src,
   output logic [INSTRET_W-1:0] instret
`ifdef ILLEGAL_INSN_TRAP_EN
   ,
   output logic                 illegal_insn
`endif
);

   // state     | meaning
   // FETCH     | read instruction at PC, PC <= PC+4 on mem_ready
   // DECODE    | ALUOut <= oldPC+imm, dispatch on opcode
   // MEM_ADDR  | ALUOut <= rs1+imm for load/store
   // MEM_RD    | load data read, wait for mem_ready
   // MEM_WB    | write load data to rd
   // MEM_WR    | store, wait for mem_ready
   // EXEC_R    | register-register ALU op
   // EXEC_I    | register-immediate ALU op
   // LUI       | ALUOut <= 0+imm
   // ALU_WB    | write ALUOut to rd
   // BRANCH    | compare rs1/rs2, load PC from ALUOut if taken
   // EXEC_JALR | ALUOut <= rs1+imm
   // JUMP      | PC <= ALUOut, ALUOut <= oldPC+4
   // TRAP      | illegal opcode, parked until reset
   typedef enum logic [3:0] {
      FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R,
      EXEC_I, LUI, ALU_WB, BRANCH, EXEC_JALR, JUMP, TRAP
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   state_t state, state_next;
   logic   taken;
   logic   retire;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= FETCH;
      else       state <= state_next;
   end

   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:         taken = alu_zero;
         3'b001:         taken = !alu_zero;
         3'b100, 3'b110: taken = alu_lsb;
         3'b101, 3'b111: taken = !alu_lsb;
         default:        taken = 1'b0;
      endcase
   end

   always_comb begin
      state_next = state;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      adr_src    = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      rf_we      = 1'b0;
      alu_ctrl   = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      result_src = 2'b00;
`ifdef ILLEGAL_INSN_TRAP_EN
      illegal_insn = 1'b0;
`endif
      case (state)
         FETCH: begin
            mem_re     = 1'b1;
            alu_ctrl   = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            if (mem_ready) begin
               ir_we      = 1'b1;
               pc_we      = 1'b1;
               state_next = DECODE;
            end
         end
         DECODE: begin
            alu_ctrl  = 1'b1;
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (opcode)
               OP_LOAD, OP_STORE:   state_next = MEM_ADDR;
               OP_R:                state_next = EXEC_R;
               OP_I:                state_next = EXEC_I;
               OP_BRANCH:           state_next = BRANCH;
               OP_JAL:              state_next = JUMP;
               OP_JALR:             state_next = EXEC_JALR;
               OP_LUI:              state_next = LUI;
               OP_AUIPC:            state_next = ALU_WB;
               OP_FENCE, OP_SYSTEM: state_next = FETCH;
`ifdef ILLEGAL_INSN_TRAP_EN
               default:             state_next = TRAP;
`else
               default:             state_next = FETCH;
`endif
            endcase
         end
         MEM_ADDR: begin
            alu_ctrl   = 1'b1;
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            state_next = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
         end
         MEM_RD: begin
            mem_re  = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) state_next = MEM_WB;
         end
         MEM_WB: begin
            result_src = 2'b01;
            rf_we      = 1'b1;
            state_next = FETCH;
         end
         MEM_WR: begin
            mem_we  = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) state_next = FETCH;
         end
         EXEC_R: begin
            alu_src_a  = 2'b10;
            state_next = ALU_WB;
         end
         EXEC_I: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            state_next = ALU_WB;
         end
         LUI: begin
            alu_ctrl   = 1'b1;
            alu_src_a  = 2'b11;
            alu_src_b  = 2'b01;
            state_next = ALU_WB;
         end
         ALU_WB: begin
            rf_we      = 1'b1;
            state_next = FETCH;
         end
         BRANCH: begin
            alu_src_a  = 2'b10;
            pc_we      = taken;
            state_next = FETCH;
         end
         EXEC_JALR: begin
            alu_ctrl   = 1'b1;
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            state_next = JUMP;
         end
         JUMP: begin
            alu_ctrl   = 1'b1;
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            pc_we      = 1'b1;
            state_next = ALU_WB;
         end
         TRAP: begin
`ifdef ILLEGAL_INSN_TRAP_EN
            illegal_insn = 1'b1;
`endif
            state_next = TRAP;
         end
         default: state_next = FETCH;
      endcase
      // Reset must silence requests immediately, even though FETCH decodes mem_re=1.
      if (!rstn) begin
         mem_re     = 1'b0;
         mem_we     = 1'b0;
         adr_src    = 1'b0;
         ir_we      = 1'b0;
         pc_we      = 1'b0;
         rf_we      = 1'b0;
         alu_ctrl   = 1'b0;
         alu_src_a  = 2'b00;
         alu_src_b  = 2'b00;
         result_src = 2'b00;
      end
   end

   assign retire = (state != FETCH) && (state_next == FETCH);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)       instret <= '0;
      else if (retire) instret <= instret + INSTRET_W'(1);
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed table-driven bench for multicycle_ctrl plus hand sequences for stall,
// mid-access reset and (with ILLEGAL_INSN_TRAP_EN) the trap state.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        alu_zero, alu_lsb, mem_ready;
   logic        mem_re, mem_we, adr_src, ir_we, pc_we, rf_we, alu_ctrl;
   logic [1:0]  alu_src_a, alu_src_b, result_src;
   logic [31:0] instret;
   logic        n_mem_re, n_mem_we, n_adr_src, n_ir_we, n_pc_we, n_rf_we, n_alu_ctrl;
   logic [1:0]  n_alu_src_a, n_alu_src_b, n_result_src;
   logic [1:0]  n_instret;
`ifdef ILLEGAL_INSN_TRAP_EN
   logic        illegal_insn, n_illegal_insn;
`endif

   multicycle_ctrl #(.INSTRET_W(32)) u_dut (
      .clk(clk), .rstn(rstn), .opcode(opcode), .funct3(funct3),
      .alu_zero(alu_zero), .alu_lsb(alu_lsb), .mem_ready(mem_ready),
      .mem_re(mem_re), .mem_we(mem_we), .adr_src(adr_src), .ir_we(ir_we),
      .pc_we(pc_we), .rf_we(rf_we), .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .result_src(result_src), .instret(instret)
`ifdef ILLEGAL_INSN_TRAP_EN
      , .illegal_insn(illegal_insn)
`endif
   );

   // Narrow counter instance to exercise wrap-around.
   multicycle_ctrl #(.INSTRET_W(2)) u_narrow (
      .clk(clk), .rstn(rstn), .opcode(opcode), .funct3(funct3),
      .alu_zero(alu_zero), .alu_lsb(alu_lsb), .mem_ready(mem_ready),
      .mem_re(n_mem_re), .mem_we(n_mem_we), .adr_src(n_adr_src), .ir_we(n_ir_we),
      .pc_we(n_pc_we), .rf_we(n_rf_we), .alu_ctrl(n_alu_ctrl), .alu_src_a(n_alu_src_a),
      .alu_src_b(n_alu_src_b), .result_src(n_result_src), .instret(n_instret)
`ifdef ILLEGAL_INSN_TRAP_EN
      , .illegal_insn(n_illegal_insn)
`endif
   );

   always #5 clk = ~clk;

   // {mem_re, mem_we, adr_src, ir_we, pc_we, rf_we, alu_ctrl, src_a, src_b, result_src}
   logic [12:0] out_v;
   assign out_v = {mem_re, mem_we, adr_src, ir_we, pc_we, rf_we, alu_ctrl,
                   alu_src_a, alu_src_b, result_src};

   localparam logic [12:0] O_F1   = 13'b1_0_0_1_1_0_1_00_10_10;
   localparam logic [12:0] O_F0   = 13'b1_0_0_0_0_0_1_00_10_10;
   localparam logic [12:0] O_DEC  = 13'b0_0_0_0_0_0_1_01_01_00;
   localparam logic [12:0] O_MADR = 13'b0_0_0_0_0_0_1_10_01_00;
   localparam logic [12:0] O_MRD  = 13'b1_0_1_0_0_0_0_00_00_00;
   localparam logic [12:0] O_MWB  = 13'b0_0_0_0_0_1_0_00_00_01;
   localparam logic [12:0] O_MWR  = 13'b0_1_1_0_0_0_0_00_00_00;
   localparam logic [12:0] O_EXR  = 13'b0_0_0_0_0_0_0_10_00_00;
   localparam logic [12:0] O_EXI  = 13'b0_0_0_0_0_0_0_10_01_00;
   localparam logic [12:0] O_LUI  = 13'b0_0_0_0_0_0_1_11_01_00;
   localparam logic [12:0] O_AWB  = 13'b0_0_0_0_0_1_0_00_00_00;
   localparam logic [12:0] O_BRT  = 13'b0_0_0_0_1_0_0_10_00_00;
   localparam logic [12:0] O_BRN  = 13'b0_0_0_0_0_0_0_10_00_00;
   localparam logic [12:0] O_JALR = 13'b0_0_0_0_0_0_1_10_01_00;
   localparam logic [12:0] O_JMP  = 13'b0_0_0_0_1_0_1_01_10_00;
   localparam logic [12:0] O_ZERO = 13'b0;

   localparam logic [6:0] ADD = 7'h33, LW = 7'h03, SW = 7'h23, BR = 7'h63, JALR = 7'h67;
   localparam logic [6:0] OPI = 7'h13, LUI = 7'h37, AUIPC = 7'h17, FENCE = 7'h0F, ILL = 7'h7F;

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        z;
      logic        l;
      logic        rdy;
      logic [12:0] exp_out;
      int          exp_inst;
      logic        exp_ill;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;

   task automatic addv(input logic [6:0] op, input logic [2:0] f3, input logic z,
                       input logic l, input logic rdy, input logic [12:0] eo,
                       input int ei, input logic ill);
      vec_t v;
      v.op = op; v.f3 = f3; v.z = z; v.l = l; v.rdy = rdy;
      v.exp_out = eo; v.exp_inst = ei; v.exp_ill = ill;
      vecs.push_back(v);
   endtask

   // FETCH, DECODE, BRANCH for one branch instruction
   task automatic add_br(input logic [2:0] f3, input logic z, input logic l,
                         input logic tk, input int ei);
      addv(BR, f3, z, l, 1'b1, O_F1, ei, 1'b0);
      addv(BR, f3, z, l, 1'b1, O_DEC, ei, 1'b0);
      addv(BR, f3, z, l, 1'b1, tk ? O_BRT : O_BRN, ei, 1'b0);
   endtask

   task automatic check(input string name, input int row, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
      end
   endtask

   initial begin
      rstn = 1'b0; opcode = '0; funct3 = '0;
      alu_zero = 1'b0; alu_lsb = 1'b0; mem_ready = 1'b0;

      // ADD: FETCH, DECODE, EXEC_R, ALU_WB
      addv(ADD, 3'd0, 0, 0, 1, O_F1, 0, 0);
      addv(ADD, 3'd0, 0, 0, 1, O_DEC, 0, 0);
      addv(ADD, 3'd0, 0, 0, 1, O_EXR, 0, 0);
      addv(ADD, 3'd0, 0, 0, 1, O_AWB, 0, 0);
      // LW with three stall cycles in MEM_RD
      addv(LW, 3'd2, 0, 0, 1, O_F1, 1, 0);
      addv(LW, 3'd2, 0, 0, 1, O_DEC, 1, 0);
      addv(LW, 3'd2, 0, 0, 0, O_MADR, 1, 0);
      addv(LW, 3'd2, 0, 0, 0, O_MRD, 1, 0);
      addv(LW, 3'd2, 0, 0, 0, O_MRD, 1, 0);
      addv(LW, 3'd2, 0, 0, 0, O_MRD, 1, 0);
      addv(LW, 3'd2, 0, 0, 1, O_MRD, 1, 0);
      addv(LW, 3'd2, 0, 0, 0, O_MWB, 1, 0);
      // branches: BEQ taken, BLTU not taken, BNE taken, BGE not taken, BLT taken, f3=010 never
      add_br(3'b000, 1, 0, 1, 2);
      add_br(3'b110, 1, 0, 0, 3);
      add_br(3'b001, 0, 1, 1, 4);
      add_br(3'b101, 0, 1, 0, 5);
      add_br(3'b100, 0, 1, 1, 6);
      add_br(3'b010, 1, 1, 0, 7);
      // JALR: EXEC_JALR, JUMP, ALU_WB
      addv(JALR, 3'd0, 0, 0, 1, O_F1, 8, 0);
      addv(JALR, 3'd0, 0, 0, 1, O_DEC, 8, 0);
      addv(JALR, 3'd0, 0, 0, 1, O_JALR, 8, 0);
      addv(JALR, 3'd0, 0, 0, 1, O_JMP, 8, 0);
      addv(JALR, 3'd0, 0, 0, 1, O_AWB, 8, 0);
      // ADDI with a fetch stall
      addv(OPI, 3'd0, 0, 0, 0, O_F0, 9, 0);
      addv(OPI, 3'd0, 0, 0, 1, O_F1, 9, 0);
      addv(OPI, 3'd0, 0, 0, 1, O_DEC, 9, 0);
      addv(OPI, 3'd0, 0, 0, 1, O_EXI, 9, 0);
      addv(OPI, 3'd0, 0, 0, 1, O_AWB, 9, 0);
      addv(LUI, 3'd0, 0, 0, 1, O_F1, 10, 0);
      addv(LUI, 3'd0, 0, 0, 1, O_DEC, 10, 0);
      addv(LUI, 3'd0, 0, 0, 1, O_LUI, 10, 0);
      addv(LUI, 3'd0, 0, 0, 1, O_AWB, 10, 0);
      addv(FENCE, 3'd0, 0, 0, 1, O_F1, 11, 0);
      addv(FENCE, 3'd0, 0, 0, 1, O_DEC, 11, 0);
      addv(AUIPC, 3'd0, 0, 0, 1, O_F1, 12, 0);
      addv(AUIPC, 3'd0, 0, 0, 1, O_DEC, 12, 0);
      addv(AUIPC, 3'd0, 0, 0, 1, O_AWB, 12, 0);
      // SW with one stall cycle
      addv(SW, 3'd2, 0, 0, 1, O_F1, 13, 0);
      addv(SW, 3'd2, 0, 0, 1, O_DEC, 13, 0);
      addv(SW, 3'd2, 0, 0, 1, O_MADR, 13, 0);
      addv(SW, 3'd2, 0, 0, 0, O_MWR, 13, 0);
      addv(SW, 3'd2, 0, 0, 1, O_MWR, 13, 0);
      // unknown opcode
      addv(ILL, 3'd0, 0, 0, 1, O_F1, 14, 0);
      addv(ILL, 3'd0, 0, 0, 1, O_DEC, 14, 0);
`ifdef ILLEGAL_INSN_TRAP_EN
      addv(ILL, 3'd0, 0, 0, 1, O_ZERO, 14, 1);
      addv(ILL, 3'd0, 0, 0, 0, O_ZERO, 14, 1);
      addv(ILL, 3'd0, 0, 0, 1, O_ZERO, 14, 1);
`else
      addv(ILL, 3'd0, 0, 0, 0, O_F0, 15, 0);
      addv(ILL, 3'd0, 0, 0, 0, O_F0, 15, 0);
`endif

      @(negedge clk);
      @(negedge clk);
      check("reset_outputs", -1, {19'd0, out_v}, {19'd0, O_ZERO});
      check("reset_instret", -1, instret, 32'd0);
      rstn = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         opcode = vecs[i].op; funct3 = vecs[i].f3;
         alu_zero = vecs[i].z; alu_lsb = vecs[i].l; mem_ready = vecs[i].rdy;
         #1;
         check("outputs", i, {19'd0, out_v}, {19'd0, vecs[i].exp_out});
         check("instret", i, instret, vecs[i].exp_inst);
         check("instret_wrap", i, {30'd0, n_instret}, vecs[i].exp_inst % 4);
`ifdef ILLEGAL_INSN_TRAP_EN
         check("illegal_insn", i, {31'd0, illegal_insn}, {31'd0, vecs[i].exp_ill});
`endif
      end

      // Reset pulsed while a store is stalled in MEM_WR
      @(negedge clk);
      rstn = 1'b0;
      #1;
      rstn = 1'b1;
      opcode = SW; funct3 = 3'd2; mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      check("memwr_we_before_rst", 100, {31'd0, mem_we}, 32'd1);
      #1;
      rstn = 1'b0;
      #1;
      check("memwr_we_in_rst", 101, {31'd0, mem_we}, 32'd0);
      check("memwr_re_in_rst", 102, {31'd0, mem_re}, 32'd0);
      check("memwr_inst_in_rst", 103, instret, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      mem_ready = 1'b1;
      #1;
      check("after_rst_fetch", 104, {19'd0, out_v}, {19'd0, O_F1});
      check("after_rst_inst", 105, instret, 32'd0);
`ifdef ILLEGAL_INSN_TRAP_EN
      check("after_rst_illegal", 106, {31'd0, illegal_insn}, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running want done");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore/Mealy control FSM for the multicycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback over the shared ALU, register file and unified memory port.
- Drives alu_ctrl into the ALU op decoder: 1 forces ADD; 0 lets the decoder derive the op from opcode/funct3/funct7.
- Evaluates branch conditions from ALU flags. Counts retired instructions.

Parameters:
INSTRET_W, 32, width of retired-instruction counter; wraps modulo 2^INSTRET_W

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
opcode  in  7  instruction opcode from IR
funct3  in  3  instruction funct3 from IR
alu_zero  in  1  ALU result == 0
alu_lsb  in  1  ALU result bit 0 (SLT/SLTU outcome)
mem_ready  in  1  memory access completes this cycle
mem_re  out  1  memory read request
mem_we  out  1  memory write request
adr_src  out  1  memory address: 0 PC, 1 ALUOut register
ir_we  out  1  latch IR and old-PC
pc_we  out  1  load PC from result mux
rf_we  out  1  register file write enable
alu_ctrl  out  1  1 forces ALU ADD
alu_src_a  out  2  00 PC, 01 old PC, 10 rs1, 11 zero
alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
result_src  out  2  00 ALUOut register, 01 memory data, 10 ALU result direct
instret  out  INSTRET_W  retired-instruction count

Behaviour:
- Reset (rstn low, async): state FETCH, instret 0. All strobes (mem_re, mem_we, ir_we, pc_we, rf_we) forced 0. Selects 0.
- Outputs are a combinational decode of state. pc_we/ir_we in FETCH and BRANCH are Mealy terms.
- Unlisted outputs in a state are 0.
- FETCH:
  - mem_re=1, adr_src=0, alu_ctrl=1, src_a=00, src_b=10, result_src=10.
  - Hold while mem_ready=0.
  - On mem_ready=1: ir_we=1, pc_we=1 (PC+4), go DECODE.
- DECODE:
  - alu_ctrl=1, src_a=01, src_b=01. ALUOut captures oldPC+imm.
  - Next state by opcode:
    - 0000011 / 0100011 -> MEM_ADDR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH
    - 1101111 -> JUMP
    - 1100111 -> EXEC_JALR
    - 0110111 -> LUI
    - 0010111 -> ALU_WB
    - 0001111 / 1110011 -> FETCH (retired as NOP)
    - other -> FETCH, or TRAP with feature
- MEM_ADDR: alu_ctrl=1, src_a=10, src_b=01. Next MEM_RD if opcode=0000011, else MEM_WR.
- MEM_RD: mem_re=1, adr_src=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: result_src=01, rf_we=1 -> FETCH.
- MEM_WR: mem_we=1, adr_src=1. Hold until mem_ready, then FETCH.
- EXEC_R: alu_ctrl=0, src_a=10, src_b=00 -> ALU_WB.
- EXEC_I: alu_ctrl=0, src_a=10, src_b=01 -> ALU_WB.
- LUI: alu_ctrl=1, src_a=11, src_b=01 -> ALU_WB.
- ALU_WB: result_src=00, rf_we=1 -> FETCH.
- BRANCH:
  - alu_ctrl=0, src_a=10, src_b=00, result_src=00.
  - taken = funct3 000: zero; 001: !zero; 100/110: lsb; 101/111: !lsb; 010/011: 0.
  - pc_we=taken. Next FETCH.
- EXEC_JALR: alu_ctrl=1, src_a=10, src_b=01 (ALUOut<=rs1+imm) -> JUMP.
- JUMP: alu_ctrl=1, src_a=01, src_b=10, result_src=00, pc_we=1 (PC<=ALUOut). ALUOut<=oldPC+4. Next ALU_WB.
- instret increments by 1 on every transition into FETCH from a non-FETCH state. Wraps all-ones -> 0.
- Memory stalls: hold state and all outputs while waiting. mem_re/mem_we stay asserted until the mem_ready cycle. No request is issued in the cycle after completion unless the next state requests.
- Reset mid-access: requests drop immediately (async). Restart at FETCH.

Optional Feature:
- Macro ILLEGAL_INSN_TRAP_EN.
- With it: unknown opcode in DECODE -> TRAP. TRAP asserts extra output illegal_insn=1 and all strobes 0. TRAP holds until reset; instret frozen.
- Without it: port absent; unknown opcode retires as NOP -> FETCH.

Test Plan:
- ADD x3,x1,x2, mem_ready always 1 -> FETCH, DECODE, EXEC_R, ALU_WB. rf_we only in cycle 4 with alu_ctrl=0. instret 0->1.
- LW with mem_ready low 3 cycles in MEM_RD -> mem_re, adr_src=1 held 4 cycles. rf_we one cycle in MEM_WB with result_src=01.
- BEQ alu_zero=1 -> pc_we=1 in BRANCH. BLTU alu_lsb=0 -> pc_we=0. Both return to FETCH.
- JALR -> EXEC_JALR, JUMP (pc_we=1, result_src=00), ALU_WB (rf_we=1). 5 cycles total.
- rstn pulsed low during MEM_WR with mem_we=1 -> mem_we=0 immediately. After release: FETCH, instret=0.
- With ILLEGAL_INSN_TRAP_EN, opcode 1111111 -> illegal_insn=1 from cycle 3, held; no strobes; instret unchanged.
